io_timer_port: RTL and testbench

IO_TIMER_PORT -- requirements
Module: io_timer_port

---
 rtl/io_timer_port.sv | 109 ++++++++++
 tb/tb_io_timer_port.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/io_timer_port.sv
// CPU port interface for an external timer: configuration register, edge-detected
// end-of-count flag with saturating missed-event counter, and a level interrupt.
module io_timer_port #(
    parameter logic [2:0] PORT_CFG  = 3'd4,
    parameter logic [2:0] PORT_STAT = 3'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic       re,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       timer_end,
    output logic [5:0] umbral,
    output logic [1:0] basetiempo,
    output logic       timer_restart,
    output logic       irq,
    input  logic       ack
);

    logic [5:0] umbral_reg;
    logic [1:0] basetiempo_reg;
    logic       restart_reg;
    logic       irq_en_reg;
    logic       flag_reg;
    logic       flag_next;
    logic [5:0] missed_reg;
    logic [5:0] missed_next;
    logic       prev_reg;
    logic [7:0] data_out_reg;
    logic [7:0] data_out_next;

    logic cfg_wr;
    logic stat_wr;
    logic clear;
    logic timer_event;

    assign cfg_wr      = we && (addr == PORT_CFG);
    assign stat_wr     = we && (addr == PORT_STAT);
    assign clear       = ack || (stat_wr && data_in[0]);
    assign timer_event = timer_end && !prev_reg;

    // An event always wins over a coincident clear, so it is never lost.
    always_comb begin
        flag_next   = flag_reg;
        missed_next = missed_reg;
        if (timer_event) begin
            if (clear) begin
                flag_next   = 1'b1;
                missed_next = 6'd0;
            end else if (flag_reg) begin
                if (missed_reg != 6'd63) begin
                    missed_next = missed_reg + 6'd1;
                end
            end else begin
                flag_next = 1'b1;
            end
        end else if (clear) begin
            flag_next   = 1'b0;
            missed_next = 6'd0;
        end
    end

    // Read mux samples pre-write register contents.
    always_comb begin
        data_out_next = 8'h00;
        if (re) begin
            if (addr == PORT_STAT) begin
                data_out_next = {flag_reg, irq_en_reg, missed_reg};
            end else if (addr == PORT_CFG) begin
                data_out_next = {umbral_reg, basetiempo_reg};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            umbral_reg     <= 6'd0;
            basetiempo_reg <= 2'd0;
            restart_reg    <= 1'b0;
            irq_en_reg     <= 1'b0;
            flag_reg       <= 1'b0;
            missed_reg     <= 6'd0;
            prev_reg       <= 1'b1;
            data_out_reg   <= 8'h00;
        end else begin
            if (cfg_wr) begin
                umbral_reg     <= data_in[7:2];
                basetiempo_reg <= data_in[1:0];
            end
            if (stat_wr) begin
                irq_en_reg <= data_in[1];
            end
            restart_reg  <= cfg_wr;
            flag_reg     <= flag_next;
            missed_reg   <= missed_next;
            prev_reg     <= timer_end;
            data_out_reg <= data_out_next;
        end
    end

    assign umbral        = umbral_reg;
    assign basetiempo    = basetiempo_reg;
    assign timer_restart = restart_reg;
    assign irq           = flag_reg & irq_en_reg;
    assign data_out      = data_out_reg;

endmodule

// File: tb/tb_io_timer_port.sv
// Directed bench for io_timer_port with hand-computed expected values.
module tb_io_timer_port;

    localparam logic [2:0] CFG  = 3'd4;
    localparam logic [2:0] STAT = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic       re;
    logic [2:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       timer_end;
    logic [5:0] umbral;
    logic [1:0] basetiempo;
    logic       timer_restart;
    logic       irq;
    logic       ack;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [7:0] q;

    io_timer_port #(.PORT_CFG(CFG), .PORT_STAT(STAT)) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .re(re),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .timer_end(timer_end),
        .umbral(umbral),
        .basetiempo(basetiempo),
        .timer_restart(timer_restart),
        .irq(irq),
        .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end else begin
            $display("ok   %s: %02h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; data_in = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] r);
        re = 1'b1; addr = a;
        step();
        re = 1'b0;
        r = data_out;
    endtask

    task automatic pulse();
        timer_end = 1'b1;
        step();
        timer_end = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; data_in = 8'h00;
        timer_end = 1'b0; ack = 1'b0;
        step(); step();
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_umbral", {2'b00, umbral}, 8'h00);
        check_eq("rst_basetiempo", {6'd0, basetiempo}, 8'h00);
        check_eq("rst_restart", {7'd0, timer_restart}, 8'h00);
        check_eq("rst_irq", {7'd0, irq}, 8'h00);
        reset = 1'b1;
        step();

        // configuration write and restart pulse
        wr(CFG, 8'hB6);
        check_eq("cfg_umbral", {2'b00, umbral}, 8'd45);
        check_eq("cfg_basetiempo", {6'd0, basetiempo}, 8'd2);
        check_eq("cfg_restart_hi", {7'd0, timer_restart}, 8'h01);
        step();
        check_eq("cfg_restart_lo", {7'd0, timer_restart}, 8'h00);
        rd(CFG, q);
        check_eq("cfg_read", q, 8'hB6);

        // back-to-back configuration writes
        we = 1'b1; addr = CFG; data_in = 8'h01;
        step();
        check_eq("b2b_restart1", {7'd0, timer_restart}, 8'h01);
        data_in = 8'h02;
        step();
        we = 1'b0;
        check_eq("b2b_restart2", {7'd0, timer_restart}, 8'h01);
        step();
        check_eq("b2b_restart_lo", {7'd0, timer_restart}, 8'h00);

        // event with irq enabled, then ack
        wr(STAT, 8'h02);
        timer_end = 1'b1;
        step();
        check_eq("evt_irq", {7'd0, irq}, 8'h01);
        timer_end = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_eq("ack_irq", {7'd0, irq}, 8'h00);
        rd(STAT, q);
        check_eq("ack_stat", q, 8'h40);

        // held-high counts once, then saturation
        wr(STAT, 8'h03);
        timer_end = 1'b1;
        repeat (10) step();
        timer_end = 1'b0;
        step();
        rd(STAT, q);
        check_eq("held_once", q, 8'hC0);
        pulse();
        rd(STAT, q);
        check_eq("missed_one", q, 8'hC1);
        repeat (70) pulse();
        rd(STAT, q);
        check_eq("missed_sat", q, 8'hFF);

        // event coincident with ack
        timer_end = 1'b1; ack = 1'b1;
        step();
        timer_end = 1'b0; ack = 1'b0;
        check_eq("evt_ack_irq", {7'd0, irq}, 8'h01);
        rd(STAT, q);
        check_eq("evt_ack_stat", q, 8'hC0);

        // event coincident with status-write clear
        pulse();
        rd(STAT, q);
        check_eq("pre_wclr_stat", q, 8'hC1);
        timer_end = 1'b1;
        wr(STAT, 8'h03);
        timer_end = 1'b0;
        rd(STAT, q);
        check_eq("evt_wclr_stat", q, 8'hC0);

        // simultaneous write and read returns old contents
        we = 1'b1; re = 1'b1; addr = CFG; data_in = 8'h55;
        step();
        we = 1'b0; re = 1'b0;
        check_eq("rw_same_old", data_out, 8'h02);
        rd(CFG, q);
        check_eq("rw_same_new", q, 8'h55);
        step();
        check_eq("idle_data_out", data_out, 8'h00);

        // writes/reads to other addresses
        wr(3'd3, 8'hFF);
        rd(CFG, q);
        check_eq("other_wr_cfg", q, 8'h55);
        rd(3'd3, q);
        check_eq("other_rd", q, 8'h00);
        rd(STAT, q);
        check_eq("other_wr_stat", q, 8'hC0);

        // config write leaves status alone
        wr(CFG, 8'hB6);
        rd(STAT, q);
        check_eq("cfg_keeps_stat", q, 8'hC0);

        // irq_en=0 with event, then enable
        wr(STAT, 8'h01);
        rd(STAT, q);
        check_eq("dis_clr_stat", q, 8'h00);
        pulse();
        check_eq("dis_irq", {7'd0, irq}, 8'h00);
        rd(STAT, q);
        check_eq("dis_stat", q, 8'h80);
        wr(STAT, 8'h02);
        check_eq("en_irq", {7'd0, irq}, 8'h01);
        rd(STAT, q);
        check_eq("en_stat", q, 8'hC0);

        // asynchronous reset mid-cycle with restart in flight and irq high
        wr(CFG, 8'hB6);
        timer_end = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_irq", {7'd0, irq}, 8'h00);
        check_eq("arst_restart", {7'd0, timer_restart}, 8'h00);
        check_eq("arst_umbral", {2'b00, umbral}, 8'h00);
        check_eq("arst_basetiempo", {6'd0, basetiempo}, 8'h00);
        check_eq("arst_data_out", data_out, 8'h00);
        step(); step();
        reset = 1'b1;
        step(); step(); step();
        check_eq("post_rst_irq", {7'd0, irq}, 8'h00);
        check_eq("post_rst_restart", {7'd0, timer_restart}, 8'h00);
        rd(STAT, q);
        check_eq("post_rst_stat", q, 8'h00);
        timer_end = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
